// File: rtl/mul_arbiter_if.sv
// Requester and multiplier handshake bundle for mul_arbiter.
// The slave modport is the arbiter view; master is the environment view.
interface mul_arbiter_if #(
    parameter int N    = 5,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*N-1:0]    rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic              mul_start;
    logic [2*N-1:0]    mul_out;
    logic              mul_finish;

    modport slave (
        input  req, req_a, req_b, mul_out, mul_finish,
        output grant, rsp_valid, rsp_data, rsp_err, busy, mul_a, mul_b, mul_start
    );

    modport master (
        output req, req_a, req_b, mul_out, mul_finish,
        input  grant, rsp_valid, rsp_data, rsp_err, busy, mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ
// requesters, with a watchdog that aborts a multiplier that never finishes.
module mul_arbiter #(
    parameter int N       = 5,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          reset,
    mul_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RELEASE} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [WW-1:0]   r_wd;

    logic            w_found;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_cand;
    logic [IW-1:0]   w_next;

    // Scan from the farthest offset down so the nearest request above ptr wins last
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = IW'((int'(r_ptr) + k) % NREQ);
            if (bus.req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        w_next = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
    end

    // Sequencer: grant in IDLE, wait for finish or watchdog in RUN, drain finish in RELEASE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_idx         <= '0;
            r_wd          <= '0;
            bus.grant     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mul_start <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    bus.grant     <= '0;
                    bus.rsp_valid <= '0;
                    bus.rsp_err   <= 1'b0;
                    if (w_found) begin
                        r_idx         <= w_idx;
                        r_ptr         <= w_next;
                        r_wd          <= '0;
                        bus.mul_a     <= bus.req_a[w_idx*N +: N];
                        bus.mul_b     <= bus.req_b[w_idx*N +: N];
                        bus.grant     <= NREQ'(1) << w_idx;
                        bus.mul_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    bus.grant <= '0;
                    if (bus.mul_finish) begin
                        bus.rsp_data  <= bus.mul_out;
                        bus.rsp_valid <= NREQ'(1) << r_idx;
                        bus.rsp_err   <= 1'b0;
                        bus.mul_start <= 1'b0;
                        r_state       <= S_RELEASE;
                    end else if (r_wd == WW'(TIMEOUT - 1)) begin
                        bus.rsp_data  <= '0;
                        bus.rsp_valid <= NREQ'(1) << r_idx;
                        bus.rsp_err   <= 1'b1;
                        bus.mul_start <= 1'b0;
                        r_state       <= S_RELEASE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_RELEASE: begin
                    bus.rsp_valid <= '0;
                    bus.rsp_err   <= 1'b0;
                    if (!bus.mul_finish) begin
                        bus.busy <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    bus.busy      <= 1'b0;
                    bus.mul_start <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: behavioural multiplier plus a grant/response scoreboard.
module tb_mul_arbiter;
    localparam int N       = 5;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;
    localparam int LAT     = N;

    typedef struct {
        logic [NREQ-1:0] v;
        logic [2*N-1:0]  d;
        logic            e;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_arbiter_if #(.N(N), .NREQ(NREQ)) bus();

    mul_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   tests = 0, fails = 0;
    int   cyc = 0, start_cyc = 0, fin_cyc = 0, grant_cyc = 0, rsp_cyc = 0;
    int   n_grant = 0, n_rsp = 0, keep = 0, r1 = 0;
    logic prev_start = 1'b0;
    bit   m_hang = 1'b0;
    int   m_sticky = 0;
    int   m_cnt, m_hold;
    int   exp_g[$];
    rsp_t exp_r[$];

    // Multiplier model: finishes LAT cycles after start, holds finish until start drops (+sticky)
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mul_finish <= 1'b0;
            bus.mul_out    <= '0;
            m_cnt          <= 0;
            m_hold         <= 0;
        end else if (bus.mul_start && !bus.mul_finish) begin
            if (!m_hang) begin
                if (m_cnt == LAT - 1) begin
                    bus.mul_finish <= 1'b1;
                    bus.mul_out    <= {{N{1'b0}}, bus.mul_a} * {{N{1'b0}}, bus.mul_b};
                    m_hold         <= m_sticky;
                    m_cnt          <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (!bus.mul_start && bus.mul_finish) begin
            if (m_hold > 0) m_hold <= m_hold - 1;
            else            bus.mul_finish <= 1'b0;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        rsp_t r;
        int   g;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mul_start && !prev_start) start_cyc = cyc;
        prev_start = bus.mul_start;
        if (bus.mul_finish) fin_cyc = cyc;
        if (bus.grant != '0) begin
            grant_cyc = cyc;
            n_grant++;
            if (exp_g.size() == 0) chk("unexpected_grant", 32'(bus.grant), 0);
            else begin
                g = exp_g.pop_front();
                chk("grant", 32'(bus.grant), 32'(1 << g));
                chk("start_at_grant", 32'(bus.mul_start), 1);
                chk("busy_at_grant", 32'(bus.busy), 1);
            end
            if (keep > 1) keep--;
            else if (keep == 1) begin keep = 0; bus.req = '0; end
            else bus.req = bus.req & ~bus.grant;
        end
        if (bus.rsp_valid != '0) begin
            rsp_cyc = cyc;
            n_rsp++;
            if (exp_r.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_valid), 0);
            else begin
                r = exp_r.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(r.v));
                chk("rsp_data", 32'(bus.rsp_data), 32'(r.d));
                chk("rsp_err", 32'(bus.rsp_err), 32'(r.e));
                chk("start_low_at_rsp", 32'(bus.mul_start), 0);
            end
        end
    endtask

    task automatic wait_grant(int target, string tag);
        for (int i = 0; i < 200 && n_grant < target; i++) tick();
        if (n_grant < target) begin
            tests++; fails++;
            $error("FAIL %s: grant count %0d expected %0d", tag, n_grant, target);
        end
    endtask

    task automatic wait_rsp(int target, string tag);
        for (int i = 0; i < 200 && n_rsp < target; i++) tick();
        if (n_rsp < target) begin
            tests++; fails++;
            $error("FAIL %s: rsp count %0d expected %0d", tag, n_rsp, target);
        end
    endtask

    task automatic set_ops(int i, int a, int b);
        bus.req_a[i*N +: N] = N'(a);
        bus.req_b[i*N +: N] = N'(b);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_mul_start"}, 32'(bus.mul_start), 0);
        chk({tag, "_mul_a"}, 32'(bus.mul_a), 0);
        chk({tag, "_mul_b"}, 32'(bus.mul_b), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // single request: 26 x 30
        set_ops(0, 26, 30);
        bus.req[0] = 1'b1;
        exp_g.push_back(0);
        exp_r.push_back('{v: 4'b0001, d: 10'd780, e: 1'b0});
        wait_grant(n_grant + 1, "single_grant");
        chk("single_mul_a", 32'(bus.mul_a), 26);
        chk("single_mul_b", 32'(bus.mul_b), 30);
        wait_rsp(n_rsp + 1, "single_rsp");
        repeat (3) tick();
        chk("single_idle_busy", 32'(bus.busy), 0);

        // back-to-back on requester 2, operands changed right after grant
        set_ops(2, 13, 13);
        bus.req[2] = 1'b1;
        exp_g.push_back(2);
        exp_r.push_back('{v: 4'b0100, d: 10'd169, e: 1'b0});
        exp_g.push_back(2);
        exp_r.push_back('{v: 4'b0100, d: 10'd961, e: 1'b0});
        wait_grant(n_grant + 1, "b2b_grant1");
        set_ops(2, 31, 31);
        bus.req[2] = 1'b1;
        wait_rsp(n_rsp + 1, "b2b_rsp1");
        r1 = rsp_cyc;
        wait_grant(n_grant + 1, "b2b_grant2");
        chk("b2b_turnaround_ge2", 32'(grant_cyc - r1 >= 2), 1);
        wait_rsp(n_rsp + 1, "b2b_rsp2");

        // hung multiplier on requester 3: abort exactly TIMEOUT cycles after start
        m_hang = 1'b1;
        set_ops(3, 7, 9);
        bus.req[3] = 1'b1;
        exp_g.push_back(3);
        exp_r.push_back('{v: 4'b1000, d: 10'd0, e: 1'b1});
        wait_rsp(n_rsp + 1, "hang_rsp");
        chk("hang_latency", 32'(rsp_cyc - start_cyc), TIMEOUT);
        m_hang = 1'b0;
        repeat (2) tick();
        chk("hang_back_idle", 32'(bus.busy), 0);

        // fairness: all requests held, pointer is back at 0
        for (int i = 0; i < NREQ; i++) set_ops(i, i + 3, i + 20);
        for (int k = 0; k < 6; k++) begin
            exp_g.push_back(k % NREQ);
            exp_r.push_back('{v: 4'(1 << (k % NREQ)),
                              d: 10'(((k % NREQ) + 3) * ((k % NREQ) + 20)), e: 1'b0});
        end
        keep = 6;
        bus.req = '1;
        wait_rsp(n_rsp + 6, "fair_rsp");

        // sticky finish: requester 0 waits until finish drops
        m_sticky = 3;
        set_ops(1, 3, 4);
        bus.req[1] = 1'b1;
        exp_g.push_back(1);
        exp_r.push_back('{v: 4'b0010, d: 10'd12, e: 1'b0});
        exp_g.push_back(0);
        exp_r.push_back('{v: 4'b0001, d: 10'd4, e: 1'b0});
        wait_grant(n_grant + 1, "sticky_grant1");
        set_ops(0, 2, 2);
        bus.req[0] = 1'b1;
        wait_rsp(n_rsp + 1, "sticky_rsp1");
        m_sticky = 0;
        r1 = rsp_cyc;
        tick();
        chk("sticky_busy_in_release", 32'(bus.busy), 1);
        wait_grant(n_grant + 1, "sticky_grant2");
        chk("sticky_grant_after_finish", 32'(grant_cyc > fin_cyc), 1);
        chk("sticky_grant_delay_ge5", 32'(grant_cyc - r1 >= 5), 1);
        wait_rsp(n_rsp + 1, "sticky_rsp2");

        // reset mid-RUN: in-flight op discarded, pending req[1] served first
        set_ops(2, 5, 6);
        set_ops(1, 11, 17);
        bus.req[2] = 1'b1;
        exp_g.push_back(2);
        wait_grant(n_grant + 1, "rst_grant2");
        bus.req[1] = 1'b1;
        repeat (2) tick();
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        repeat (2) tick();
        #2;
        reset = 1'b0;
        exp_g.push_back(1);
        exp_r.push_back('{v: 4'b0010, d: 10'd187, e: 1'b0});
        wait_rsp(n_rsp + 1, "rst_rsp1");
        repeat (4) tick();
        chk("scoreboard_empty", 32'(exp_g.size() + exp_r.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one sequential N-bit multiplier (`mul`) among NREQ requesters. It accepts operand pairs from requesters and drives the multiplier's start/finish handshake. It returns each 2N-bit product to the issuing requester, with a watchdog that aborts a hung operation. It sits between the requesting blocks and a single `mul` instance.

## Interface
- `N`, 5, operand width in bits; product width is 2N
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 32, maximum cycles in RUN before abort (must be > N+2)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  NREQ  per-requester request level; held high until the requester's `grant` bit pulses
- `req_a`  in  NREQ*N  operand A; requester i occupies bits [i*N +: N]
- `req_b`  in  NREQ*N  operand B, same packing as `req_a`
- `grant`  out  NREQ  one-hot, one-cycle pulse: operands captured
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: result for that requester
- `rsp_data`  out  2N  product; valid only while `rsp_valid` is nonzero
- `rsp_err`  out  1  qualifies `rsp_valid`: 1 means timeout abort
- `busy`  out  1  high whenever the FSM is not in IDLE
- `mul_a`, `mul_b`  out  N  operands to the multiplier; stable for the whole operation
- `mul_start`  out  1  multiplier start; level, held high until finish or abort
- `mul_out`  in  2N  multiplier product
- `mul_finish`  in  1  multiplier done level

## Operation
- FSM states: IDLE, RUN, RELEASE.
- **IDLE**
  - If any `req` bit is high at an edge, select the winner round-robin: search upward from `ptr`, wrapping mod NREQ.
  - Latch the winner index and its operands into `mul_a`/`mul_b`.
  - Set `grant[idx]`, set `ptr` = idx+1 mod NREQ, and go to RUN.
  - If no request, stay in IDLE.
- **RUN**
  - `mul_start`=1 and the watchdog counter `wd` increments each cycle.
  - On an edge with `mul_finish`=1:
    - Register `rsp_data` = `mul_out`, `rsp_valid[idx]`=1, `rsp_err`=0.
    - Go to RELEASE.
  - Else, if `wd` = TIMEOUT-1:
    - Register `rsp_data` = 0, `rsp_valid[idx]`=1, `rsp_err`=1.
    - Go to RELEASE.
  - If finish and timeout coincide, finish wins.
- **RELEASE**
  - `mul_start`=0.
  - Stay until `mul_finish` is sampled low, then go to IDLE.
  - RELEASE lasts a minimum of 1 cycle.
- `req` bits are ignored outside IDLE; requests stay pending and are not lost.
- `ptr` resets to 0, so requester 0 has top priority after reset.
- Products are unsigned, with no truncation: the maximum (2^N-1)^2 fits in 2N bits.
- Requester operands are sampled only on the grant edge. A requester may change them after `grant`.

## Timing
- All outputs are registered.
- Reset values: `grant`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `mul_start`=0, `mul_a`=0, `mul_b`=0.
- Internal reset values: FSM=IDLE, `ptr`=0, `wd`=0.
- Edge E0: `req` sampled in IDLE. In the cycle after E0:
  - `grant[idx]`=1 for that cycle only.
  - `mul_start`=1, `busy`=1, operands valid.
- If `mul_finish` is first sampled high at edge Ef, `rsp_valid` is high in the cycle after Ef and `mul_start` falls in the same cycle.
- Turnaround: the earliest next `grant` is 2 cycles after `rsp_valid`, given that `mul_finish` drops immediately.
- Timeout: `rsp_err` pulses exactly TIMEOUT cycles after `mul_start` rose.
- `wd` clears on entry to RUN.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - The in-flight operation is discarded and no response is issued.
  - The requester must re-request.
- `mul_finish` already high on entry to RUN is treated as finish at the first RUN edge.

## Test plan
- Single request, N=5: requester 0 with a=26, b=30 -> one `grant[0]` pulse, `mul_start` high until finish, `rsp_valid[0]` with `rsp_data`=780, `rsp_err`=0.
- Back-to-back: requester 2 with 13x13, then 31x31 -> `rsp_data`=169, then 961. Next `grant[2]` occurs no earlier than 2 cycles after the first `rsp_valid`.
- Fairness: all four `req` held high continuously -> grant order 0,1,2,3,0,1. No requester is granted twice before the others are served.
- Hung multiplier: model holds `mul_finish`=0 -> `rsp_valid[idx]`=1 with `rsp_err`=1 and `rsp_data`=0 exactly 32 cycles after `mul_start` rose; FSM then returns to IDLE.
- Sticky finish: model holds `mul_finish` high 3 extra cycles after completion -> FSM stays in RELEASE and no `grant` occurs until finish is low.
- Reset mid-RUN: assert `reset` between clock edges during an operation -> all outputs 0 immediately and no `rsp_valid`. After release, a pending `req[1]` is granted first, since `ptr`=0 and no `req[0]` is pending.
